// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and Gray/binary helpers.
package fifo_pkg;

    localparam int unsigned FIFO_ASIZE = 4;
    localparam int unsigned DEPTH      = 2 ** FIFO_ASIZE;
    localparam int unsigned PTR_W      = FIFO_ASIZE + 1;

    // Width-agnostic: callers cast the result down to their pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Only the low 'width' bits of 'gray' are meaningful.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int unsigned width);
        logic [31:0] bin;
        bin = '0;
        for (int i = 31; i >= 0; i--) begin
            if (i < int'(width)) begin
                bin[i] = gray[i] ^ ((i == 31) ? 1'b0 : bin[i+1]);
            end
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module fifo_gray2bin #(
    parameter int unsigned W = 5
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < int'(W); i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, empty/almost-empty/level status and sticky underflow for the async FIFO.
module fifo_rptr_empty
    import fifo_pkg::*;
#(
    parameter int unsigned ASIZE     = 4,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrstn_n,
    input  logic             rinc,
    input  logic             rerr_clr,
    input  logic [ASIZE:0]   rs_wptr,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   rlevel,
    output logic             runderflow
);

    localparam int unsigned PtrW = ASIZE + 1;

    logic [ASIZE:0] rbin_q, rbin_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic [ASIZE:0] rlevel_q, rlevel_d;
    logic           rempty_q, rempty_d;
    logic           rae_q, rae_d;
    logic           runderflow_q, runderflow_d;
    logic [ASIZE:0] wbin_s;
    logic           rd_ok;

    fifo_gray2bin #(
        .W (PtrW)
    ) u_wptr_g2b (
        .gray_i (rs_wptr),
        .bin_o  (wbin_s)
    );

    // Next-state: flags are derived from the post-pop pointer so they move on the same edge.
    always_comb begin
        rd_ok        = rinc & ~rempty_q;
        rbin_d       = rbin_q + {{ASIZE{1'b0}}, rd_ok};
        rptr_d       = PtrW'(bin2gray(32'(rbin_d)));
        rempty_d     = (rptr_d == rs_wptr);
        rlevel_d     = wbin_s - rbin_d;
        rae_d        = (32'(rlevel_d) <= AE_THRESH);
        // Set has priority over clear.
        runderflow_d = (rinc & rempty_q) | (runderflow_q & ~rerr_clr);
    end

    // State update with synchronous active-low reset overriding all inputs.
    always_ff @(posedge rclk) begin
        if (!rrstn_n) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rlevel_q     <= '0;
            rempty_q     <= 1'b1;
            rae_q        <= 1'b1;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rptr_d;
            rlevel_q     <= rlevel_d;
            rempty_q     <= rempty_d;
            rae_q        <= rae_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign raddr         = rbin_q[ASIZE-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = rae_q;
    assign rlevel        = rlevel_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Self-checking bench for fifo_rptr_empty (ASIZE=4, AE_THRESH=2).
module tb_fifo_rptr_empty;

    typedef struct packed {
        logic       e;
        logic       ae;
        logic [4:0] lvl;
        logic [4:0] ptr;
        logic [3:0] addr;
        logic       uf;
    } out_t;

    typedef struct packed {
        logic       rstn;
        logic       inc;
        logic       clr;
        logic [4:0] wptr;
        out_t       exp;
    } vec_t;

    logic       rclk = 1'b0;
    logic       rrstn_n = 1'b0;
    logic       rinc = 1'b0;
    logic       rerr_clr = 1'b0;
    logic [4:0] rs_wptr = '0;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [4:0] rlevel;
    logic       runderflow;

    int n_cmp = 0;
    int n_bad = 0;
    out_t exp_q[$];

    // Independent reference state for the hand-written sequences.
    logic [4:0] m_bin;
    logic       m_empty;
    logic       m_uf;

    fifo_rptr_empty #(
        .ASIZE     (4),
        .AE_THRESH (2)
    ) dut (
        .rclk          (rclk),
        .rrstn_n       (rrstn_n),
        .rinc          (rinc),
        .rerr_clr      (rerr_clr),
        .rs_wptr       (rs_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .rlevel        (rlevel),
        .runderflow    (runderflow)
    );

    always #5 rclk = ~rclk;

    function automatic logic [4:0] tb_gray(input logic [4:0] b);
        logic [4:0] g;
        for (int i = 0; i < 4; i++) g[i] = b[i] ^ b[i+1];
        g[4] = b[4];
        return g;
    endfunction

    function automatic logic [4:0] tb_ungray(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle, queue its expectation, sample after the edge and compare.
    task automatic apply(input logic rstn, input logic inc, input logic clr,
                         input logic [4:0] wptr, input out_t exp, input int id);
        out_t got;
        out_t want;
        @(negedge rclk);
        rrstn_n  = rstn;
        rinc     = inc;
        rerr_clr = clr;
        rs_wptr  = wptr;
        exp_q.push_back(exp);
        @(posedge rclk);
        #1;
        got = '{e: rempty, ae: ralmost_empty, lvl: rlevel, ptr: rptr, addr: raddr,
                uf: runderflow};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL step%0d scoreboard empty", id);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                n_bad++;
                $display("FAIL step%0d got e=%b ae=%b lvl=%0d ptr=%b addr=%0d uf=%b required e=%b ae=%b lvl=%0d ptr=%b addr=%0d uf=%b",
                         id, got.e, got.ae, got.lvl, got.ptr, got.addr, got.uf,
                         want.e, want.ae, want.lvl, want.ptr, want.addr, want.uf);
            end
        end
    endtask

    // Advance the reference model one edge and check the DUT against it.
    task automatic model_step(input logic rstn, input logic inc, input logic clr,
                              input logic [4:0] wptr, input int id);
        out_t       e;
        logic [4:0] nb;
        logic [4:0] lvl;
        if (!rstn) begin
            m_bin   = '0;
            m_empty = 1'b1;
            m_uf    = 1'b0;
            e = '{e: 1'b1, ae: 1'b1, lvl: 5'd0, ptr: 5'd0, addr: 4'd0, uf: 1'b0};
        end else begin
            nb      = m_bin + 5'((inc && !m_empty) ? 1 : 0);
            lvl     = tb_ungray(wptr) - nb;
            m_uf    = (inc & m_empty) | (m_uf & ~clr);
            m_empty = (tb_gray(nb) == wptr);
            m_bin   = nb;
            e = '{e: m_empty, ae: (lvl <= 5'd2), lvl: lvl, ptr: tb_gray(nb), addr: nb[3:0],
                  uf: m_uf};
        end
        apply(rstn, inc, clr, wptr, e, id);
    endtask

    initial begin
        vec_t       vecs[12];
        logic [4:0] prev_ptr;

        // Reset, fill detect, drain, underflow set/hold/clear/set-wins.
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0}};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00000, 4'd0, 1'b0}};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'b00010, '{1'b0, 1'b0, 5'd3, 5'b00000, 4'd0, 1'b0}};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'b00010, '{1'b0, 1'b1, 5'd2, 5'b00001, 4'd1, 1'b0}};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'b00010, '{1'b0, 1'b1, 5'd1, 5'b00011, 4'd2, 1'b0}};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b0}};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1}};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1}};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1}};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b0}};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b1}};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 5'b00010, '{1'b1, 1'b1, 5'd0, 5'b00010, 4'd3, 1'b0}};

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rstn, vecs[i].inc, vecs[i].clr, vecs[i].wptr, vecs[i].exp, i);
        end

        // Full FIFO: writer 16 ahead of a freshly reset reader, then drain to rbin=16.
        model_step(1'b0, 1'b0, 1'b0, 5'b00000, 100);
        model_step(1'b1, 1'b0, 1'b0, 5'b11000, 101);
        for (int i = 0; i < 16; i++) begin
            model_step(1'b1, 1'b1, 1'b0, 5'b11000, 200 + i);
        end
        model_step(1'b1, 1'b1, 1'b0, 5'b11000, 216);

        // Writer wraps to 0 (= 32); drain across the MSB wrap, Gray must move one bit per pop.
        model_step(1'b1, 1'b0, 1'b0, 5'b00000, 300);
        for (int i = 0; i < 16; i++) begin
            prev_ptr = rptr;
            model_step(1'b1, 1'b1, 1'b0, 5'b00000, 400 + i);
            n_cmp++;
            if ($countones(prev_ptr ^ rptr) != 1) begin
                n_bad++;
                $display("FAIL gray_step%0d got %b->%b required one-bit change", i, prev_ptr, rptr);
            end
        end

        // Mid-stream reset with a read pending: no pop may be counted.
        model_step(1'b1, 1'b0, 1'b0, 5'b00111, 500);
        model_step(1'b0, 1'b1, 1'b0, 5'b00111, 501);
        model_step(1'b1, 1'b0, 1'b0, 5'b00111, 502);
        model_step(1'b1, 1'b1, 1'b0, 5'b00111, 503);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
